// File: rtl/iram_loader_pkg.sv
// Shared monitor-link definitions for the instruction RAM loader:
// opcodes, FSM state encodings and small helpers.
package iram_loader_pkg;

    localparam int WORD_W = 32;
    localparam int BYTE_W = 8;

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] OP_GO    = 8'h47;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ADDR  = 3'd1;
    localparam logic [2:0] ST_CNT   = 3'd2;
    localparam logic [2:0] ST_WDATA = 3'd3;
    localparam logic [2:0] ST_RREQ  = 3'd4;
    localparam logic [2:0] ST_RWAIT = 3'd5;
    localparam logic [2:0] ST_RSEND = 3'd6;
    localparam logic [2:0] ST_GO    = 3'd7;

    typedef enum logic [1:0] {
        CMD_WRITE,
        CMD_READ,
        CMD_GO
    } cmd_e;

    function automatic logic isReadState(input logic [2:0] st);
        return (st == ST_RREQ) || (st == ST_RWAIT) || (st == ST_RSEND);
    endfunction

endpackage

// File: rtl/iram_byte_shifter.sv
// Shared 32-bit shift register: assembles little-endian words from incoming
// bytes and serializes captured words back out LSB first.
module iram_byte_shifter
    import iram_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              shift_in_i,
    input  logic [BYTE_W-1:0] byte_i,
    input  logic              load_i,
    input  logic [WORD_W-1:0] word_i,
    input  logic              shift_out_i,
    output logic [WORD_W-1:0] assembled_o,
    output logic [BYTE_W-1:0] byte_o
);

    logic [WORD_W-1:0] word_q;

    // New bytes enter at the top so the first byte ends up in bits [7:0].
    assign assembled_o = {byte_i, word_q[WORD_W-1:BYTE_W]};
    assign byte_o      = word_q[BYTE_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
        end else if (load_i) begin
            word_q <= word_i;
        end else if (shift_in_i) begin
            word_q <= assembled_o;
        end else if (shift_out_i) begin
            word_q <= {{BYTE_W{1'b0}}, word_q[WORD_W-1:BYTE_W]};
        end
    end

endmodule

// File: rtl/iram_loader.sv
// Monitor-link command engine that writes, reads back and launches code in
// the instruction RAM from a byte stream (write 'W', read 'R', go 'G').
module iram_loader
    import iram_loader_pkg::*;
#(
    parameter int IWIDTH = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [IWIDTH-1:0] i_ram_wadr,
    output logic [31:0]       i_ram_wdata,
    output logic              i_ram_wen,
    output logic [IWIDTH-1:0] i_ram_radr,
    input  logic [31:0]       i_ram_rdata,
    output logic              i_read_sel,
    output logic              cpu_start,
    output logic [29:0]       start_adr,
    output logic              busy
);

    logic [2:0]        state_q, state_d;
    cmd_e              cmd_q, cmd_d;
    logic [1:0]        byteCnt_q, byteCnt_d;
    logic [31:0]       addr_q, addr_d;
    logic [15:0]       count_q, count_d;
    logic              wen_q, wen_d;
    logic [IWIDTH-1:0] wadr_q, wadr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [29:0]       startAdr_q, startAdr_d;

    logic [31:0] assembled;
    logic [7:0]  txByte;
    logic        txFire;

    assign tx_valid    = (state_q == ST_RSEND);
    assign txFire      = tx_valid && tx_ready;
    assign tx_data     = tx_valid ? txByte : 8'h00;
    assign i_ram_wen   = wen_q;
    assign i_ram_wadr  = wadr_q;
    assign i_ram_wdata = wdata_q;
    assign i_ram_radr  = addr_q[IWIDTH+1:2];
    assign i_read_sel  = isReadState(state_q);
    assign cpu_start   = (state_q == ST_GO);
    assign start_adr   = startAdr_q;
    assign busy        = (state_q != ST_IDLE);

    iram_byte_shifter u_shifter (
        .clk         (clk),
        .rst_n       (rst_n),
        .shift_in_i  ((state_q == ST_WDATA) && rx_valid),
        .byte_i      (rx_data),
        .load_i      (state_q == ST_RWAIT),
        .word_i      (i_ram_rdata),
        .shift_out_i (txFire),
        .assembled_o (assembled),
        .byte_o      (txByte)
    );

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        byteCnt_d  = byteCnt_q;
        addr_d     = addr_q;
        count_d    = count_q;
        wen_d      = 1'b0;
        wadr_d     = wadr_q;
        wdata_d    = wdata_q;
        startAdr_d = startAdr_q;

        case (state_q)
            ST_IDLE: begin
                byteCnt_d = 2'd0;
                if (rx_valid) begin
                    if (rx_data == OP_WRITE) begin
                        cmd_d   = CMD_WRITE;
                        state_d = ST_ADDR;
                    end else if (rx_data == OP_READ) begin
                        cmd_d   = CMD_READ;
                        state_d = ST_ADDR;
                    end else if (rx_data == OP_GO) begin
                        cmd_d   = CMD_GO;
                        state_d = ST_ADDR;
                    end
                end
            end
            ST_ADDR: begin
                if (rx_valid) begin
                    addr_d    = {addr_q[23:0], rx_data};
                    byteCnt_d = byteCnt_q + 2'd1;
                    if (byteCnt_q == 2'd3) begin
                        if (cmd_q == CMD_GO) begin
                            state_d    = ST_GO;
                            startAdr_d = addr_d[31:2];
                        end else begin
                            state_d = ST_CNT;
                        end
                    end
                end
            end
            ST_CNT: begin
                if (rx_valid) begin
                    count_d = {count_q[7:0], rx_data};
                    if (byteCnt_q == 2'd0) begin
                        byteCnt_d = 2'd1;
                    end else begin
                        byteCnt_d = 2'd0;
                        if (count_d == 16'd0)        state_d = ST_IDLE;
                        else if (cmd_q == CMD_WRITE) state_d = ST_WDATA;
                        else                         state_d = ST_RREQ;
                    end
                end
            end
            ST_WDATA: begin
                if (rx_valid) begin
                    byteCnt_d = byteCnt_q + 2'd1;
                    if (byteCnt_q == 2'd3) begin
                        wen_d   = 1'b1;
                        wadr_d  = addr_q[IWIDTH+1:2];
                        wdata_d = assembled;
                        addr_d  = addr_q + 32'd4;
                        count_d = count_q - 16'd1;
                        if (count_q == 16'd1) state_d = ST_IDLE;
                    end
                end
            end
            ST_RREQ: begin
                state_d = ST_RWAIT;
            end
            // The read word lands in the shifter this cycle, so advance now.
            ST_RWAIT: begin
                state_d   = ST_RSEND;
                byteCnt_d = 2'd0;
                addr_d    = addr_q + 32'd4;
                count_d   = count_q - 16'd1;
            end
            ST_RSEND: begin
                if (txFire) begin
                    byteCnt_d = byteCnt_q + 2'd1;
                    if (byteCnt_q == 2'd3) begin
                        state_d = (count_q != 16'd0) ? ST_RREQ : ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cmd_q      <= CMD_WRITE;
            byteCnt_q  <= 2'd0;
            addr_q     <= '0;
            count_q    <= '0;
            wen_q      <= 1'b0;
            wadr_q     <= '0;
            wdata_q    <= '0;
            startAdr_q <= '0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            byteCnt_q  <= byteCnt_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            wen_q      <= wen_d;
            wadr_q     <= wadr_d;
            wdata_q    <= wdata_d;
            startAdr_q <= startAdr_d;
        end
    end

endmodule

// File: tb/tb_iram_loader.sv
// Self-checking bench for iram_loader: a RAM model plus write/readback
// scoreboards fed by a vector table and a few hand-built command sequences.
module tb_iram_loader;

    localparam int IW = 12;

    logic          clk;
    logic          rst_n;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic [IW-1:0] i_ram_wadr;
    logic [31:0]   i_ram_wdata;
    logic          i_ram_wen;
    logic [IW-1:0] i_ram_radr;
    logic [31:0]   ramRdata;
    logic          i_read_sel;
    logic          cpu_start;
    logic [29:0]   start_adr;
    logic          busy;

    iram_loader #(.IWIDTH(IW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .i_ram_wadr  (i_ram_wadr),
        .i_ram_wdata (i_ram_wdata),
        .i_ram_wen   (i_ram_wen),
        .i_ram_radr  (i_ram_radr),
        .i_ram_rdata (ramRdata),
        .i_read_sel  (i_read_sel),
        .cpu_start   (cpu_start),
        .start_adr   (start_adr),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [0:(1<<IW)-1];
    always @(posedge clk) begin
        if (i_ram_wen) mem[i_ram_wadr] <= i_ram_wdata;
        ramRdata <= mem[i_ram_radr];
    end

    typedef struct {
        logic [IW-1:0] adr;
        logic [31:0]   data;
    } wrRec_t;

    typedef struct {
        logic [31:0]   byteAdr;
        logic [31:0]   data;
        logic [IW-1:0] expWadr;
    } vec_t;

    wrRec_t      wrQ [$];
    logic [7:0]  txQ [$];
    wrRec_t      gotWr;
    logic [7:0]  gotTx;
    int          compared = 0;
    int          mismatched = 0;
    int          txSeen = 0;
    int          startPulses = 0;
    logic [29:0] expStartAdr = '0;
    vec_t        vecs [6];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic failNow(input string name, input logic [63:0] act);
        compared++;
        mismatched++;
        $display("[TB] FAIL %s: got 0x%0h, expected nothing", name, act);
    endtask

    // Scoreboard side: every write, readback byte and start pulse is checked here.
    always @(negedge clk) begin
        if (rst_n) begin
            if (i_ram_wen) begin
                if (wrQ.size() == 0) begin
                    failNow("unexpected_wen", {20'h0, i_ram_wadr, i_ram_wdata});
                end else begin
                    gotWr = wrQ.pop_front();
                    checkOutput("wen_wadr", i_ram_wadr, gotWr.adr);
                    checkOutput("wen_wdata", i_ram_wdata, gotWr.data);
                end
            end
            if (tx_valid && tx_ready) begin
                txSeen++;
                if (txQ.size() == 0) begin
                    failNow("unexpected_tx", tx_data);
                end else begin
                    gotTx = txQ.pop_front();
                    checkOutput("tx_byte", tx_data, gotTx);
                end
            end
            if (cpu_start) begin
                startPulses++;
                checkOutput("start_adr", start_adr, expStartAdr);
                checkOutput("wen_with_start", i_ram_wen, 1'b0);
            end
        end
    end

    task automatic applyStimulus(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_data  = b;
        rx_valid = 1'b1;
    endtask

    task automatic endStimulus();
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic sendHeader(input logic [7:0] op, input logic [31:0] adr);
        applyStimulus(op);
        for (int i = 3; i >= 0; i--) applyStimulus(adr[i*8 +: 8]);
    endtask

    task automatic sendCount(input logic [15:0] c);
        applyStimulus(c[15:8]);
        applyStimulus(c[7:0]);
    endtask

    task automatic sendWord(input logic [31:0] w);
        for (int i = 0; i < 4; i++) applyStimulus(w[i*8 +: 8]);
    endtask

    task automatic expectReadWord(input logic [31:0] w);
        for (int i = 0; i < 4; i++) txQ.push_back(w[i*8 +: 8]);
    endtask

    task automatic waitIdle(input int budget, input logic checkSel);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < budget) begin
            if (checkSel) checkOutput("read_sel", i_read_sel, 1'b1);
            n++;
            @(negedge clk);
        end
        checkOutput("busy_after_cmd", busy, 1'b0);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_wdata"}, i_ram_wdata, 32'h0);
        checkOutput({tag, "_start_adr"}, start_adr, 30'h0);
        checkOutput({tag, "_adrs"}, {i_ram_wadr, i_ram_radr}, 24'h0);
        checkOutput({tag, "_ctrl"}, {tx_valid, tx_data, i_ram_wen, i_read_sel, cpu_start, busy}, 13'h0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        int n;

        vecs[0] = '{32'h0000_0200, 32'hDEAD_BEEF, 12'h080};
        vecs[1] = '{32'h0000_0207, 32'h1234_5678, 12'h081};
        vecs[2] = '{32'hFFFF_0010, 32'hA5A5_0F0F, 12'h004};
        vecs[3] = '{32'h0000_3FFC, 32'hCAFE_F00D, 12'hFFF};
        vecs[4] = '{32'h0000_1000, 32'h0000_0001, 12'h400};
        vecs[5] = '{32'h0000_0004, 32'h8000_0000, 12'h001};

        rst_n    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkResetOutputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Table: single-word writes, then read each one back.
        for (int i = 0; i < 6; i++) begin
            wrQ.push_back('{vecs[i].expWadr, vecs[i].data});
            sendHeader(OP_W(), vecs[i].byteAdr);
            sendCount(16'd1);
            sendWord(vecs[i].data);
            endStimulus();
            waitIdle(50, 1'b0);
            @(posedge clk);
            checkOutput("wr_drained", wrQ.size(), 0);
        end
        for (int i = 0; i < 6; i++) begin
            expectReadWord(vecs[i].data);
            sendHeader(8'h52, vecs[i].byteAdr);
            sendCount(16'd1);
            endStimulus();
            waitIdle(100, 1'b1);
            @(posedge clk);
            checkOutput("tx_drained", txQ.size(), 0);
        end

        // Two-word write with a byte arriving during the write-enable cycle.
        wrQ.push_back('{12'h040, 32'h0000_0013});
        wrQ.push_back('{12'h041, 32'h0010_0093});
        sendHeader(8'h57, 32'h0000_0100);
        sendCount(16'd2);
        sendWord(32'h0000_0013);
        sendWord(32'h0010_0093);
        endStimulus();
        waitIdle(50, 1'b0);
        @(posedge clk);
        checkOutput("two_word_writes", wrQ.size(), 0);

        // Readback with a 5-cycle sink stall mid-stream.
        expectReadWord(32'h0000_0013);
        expectReadWord(32'h0010_0093);
        base = txSeen;
        sendHeader(8'h52, 32'h0000_0100);
        sendCount(16'd2);
        endStimulus();
        n = 0;
        while ((txSeen - base) < 2 && n < 200) begin
            @(negedge clk);
            checkOutput("read_sel_pre", i_read_sel, 1'b1);
            n++;
        end
        @(posedge clk);
        #1;
        tx_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        tx_ready = 1'b1;
        waitIdle(200, 1'b1);
        @(posedge clk);
        checkOutput("stall_tx_count", txSeen - base, 8);
        checkOutput("stall_tx_drained", txQ.size(), 0);

        // Go command.
        expStartAdr = 30'h0000_0080;
        base = startPulses;
        sendHeader(8'h47, 32'h0000_0200);
        endStimulus();
        waitIdle(20, 1'b0);
        repeat (10) @(posedge clk);
        checkOutput("start_pulses", startPulses - base, 1);
        checkOutput("start_adr_held", start_adr, 30'h0000_0080);

        // Address wrap across the top of the RAM.
        wrQ.push_back('{12'hFFF, 32'h1111_2222});
        wrQ.push_back('{12'h000, 32'h3333_4444});
        sendHeader(8'h57, 32'h0000_3FFC);
        sendCount(16'd2);
        sendWord(32'h1111_2222);
        sendWord(32'h3333_4444);
        endStimulus();
        waitIdle(50, 1'b0);
        @(posedge clk);
        checkOutput("wrap_writes", wrQ.size(), 0);

        // Unknown opcode is discarded; zero count ends with no RAM access.
        applyStimulus(8'h41);
        endStimulus();
        @(negedge clk);
        checkOutput("bad_opcode_busy", busy, 1'b0);
        sendHeader(8'h57, 32'h0000_0040);
        sendCount(16'd0);
        endStimulus();
        @(negedge clk);
        checkOutput("zero_count_busy", busy, 1'b0);

        // Reset mid-word aborts without writing the partial word.
        sendHeader(8'h57, 32'h0000_0040);
        sendCount(16'd1);
        applyStimulus(8'hAA);
        applyStimulus(8'hBB);
        endStimulus();
        #2;
        rst_n = 1'b0;
        @(negedge clk);
        checkResetOutputs("abort");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        checkOutput("abort_busy", busy, 1'b0);
        checkOutput("final_wr_queue", wrQ.size(), 0);
        checkOutput("final_tx_queue", txQ.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    function automatic logic [7:0] OP_W();
        return 8'h57;
    endfunction

endmodule

// File: doc/iram_loader.md
IRAM_LOADER -- requirements
Module: iram_loader

Interface
REQ-001 SHALL have parameter IWIDTH, default 12: instruction RAM word-address width, so the RAM holds 2^IWIDTH words.
REQ-002 SHALL have port clk, input, 1: clock.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port rx_data, input, 8: command/data byte from the monitor link.
REQ-005 SHALL have port rx_valid, input, 1: one-cycle strobe marking rx_data valid.
REQ-006 SHALL have port tx_data, output, 8: readback byte.
REQ-007 SHALL have port tx_valid, output, 1: tx_data valid; held until accepted.
REQ-008 SHALL have port tx_ready, input, 1: sink accepts tx_data.
REQ-009 SHALL have port i_ram_wadr, output, IWIDTH: instruction RAM word write address.
REQ-010 SHALL have port i_ram_wdata, output, 32: instruction RAM write data.
REQ-011 SHALL have port i_ram_wen, output, 1: instruction RAM write enable.
REQ-012 SHALL have port i_ram_radr, output, IWIDTH: instruction RAM monitor read address.
REQ-013 SHALL have port i_ram_rdata, input, 32: instruction RAM read data, valid one cycle after i_ram_radr.
REQ-014 SHALL have port i_read_sel, output, 1: selects the monitor read address at the RAM.
REQ-015 SHALL have port cpu_start, output, 1: one-cycle CPU start pulse.
REQ-016 SHALL have port start_adr, output, 30: CPU start word address, bits [31:2].
REQ-017 SHALL have port busy, output, 1: high whenever state is not IDLE.

Function
REQ-018 SHALL implement FSM states IDLE, ADDR, CNT, WDATA, RREQ, RWAIT, RSEND, GO.
REQ-019 In IDLE, an opcode byte SHALL select the command: 0x57 write, 0x52 read, 0x47 go; any other byte is discarded and the FSM stays in IDLE.
REQ-020 ADDR SHALL take 4 bytes, big-endian, as a byte address; bits [1:0] are ignored and the word address is bits [31:2].
REQ-021 After ADDR, write and read SHALL go to CNT, and go SHALL go to GO.
REQ-022 CNT SHALL take 2 bytes, big-endian, as the word count; a count of 0 returns to IDLE with no RAM access.
REQ-023 WDATA SHALL assemble each word from 4 bytes, little-endian (first byte = bits [7:0]).
REQ-024 On the 4th byte of a word, i_ram_wen SHALL pulse high for exactly 1 cycle on the following cycle, with i_ram_wadr = current address [IWIDTH+1:2] and i_ram_wdata = the assembled word.
REQ-025 After each RAM write or read, the address SHALL increment by 1 word and the count decrement by 1.
REQ-026 The RAM address SHALL wrap modulo 2^IWIDTH; upper address bits are ignored.
REQ-027 When the count reaches 0, the FSM SHALL return to IDLE.
REQ-028 i_read_sel SHALL be high in RREQ, RWAIT and RSEND, and low otherwise.
REQ-029 In RREQ, i_ram_radr SHALL be driven with the current address.
REQ-030 In RWAIT, i_ram_rdata SHALL be captured into a word register.
REQ-031 RSEND SHALL emit the 4 bytes of the captured word LSB first.
REQ-032 tx_valid/tx_data SHALL stay stable until tx_ready is high; a byte transfers in any cycle where tx_valid & tx_ready.
REQ-033 After the 4th byte transfers, the FSM SHALL go to RREQ if the count is nonzero, otherwise to IDLE.
REQ-034 GO SHALL assert cpu_start for exactly 1 cycle with start_adr = received address [31:2], then return to IDLE.
REQ-035 start_adr SHALL hold its value until the next go command.
REQ-036 rx_valid in RREQ, RWAIT, RSEND or GO SHALL be dropped without any state change.
REQ-037 rx_valid is honoured in every cycle of the receive states, including the cycle i_ram_wen is high.
REQ-038 i_ram_wen and cpu_start SHALL never be high in the same cycle.

Reset
REQ-039 On rst_n low, the FSM SHALL be IDLE.
REQ-040 On rst_n low, all outputs SHALL be 0, including tx_valid, i_ram_wen, i_read_sel, cpu_start, start_adr and busy.
REQ-041 On rst_n low, byte and word counters SHALL be cleared.
REQ-042 Reset mid-command SHALL abort the command, and the partial word SHALL NOT be written.

Structure
REQ-043 Opcode constants and state encodings SHALL live in a shared package with the other monitor definitions.
REQ-044 The byte-to-word assembler and word-to-byte serializer SHALL be a single sub-module, iram_byte_shifter.

Verification
REQ-045 Write 0x57, 00 00 01 00, 00 02, 13 00 00 00, 93 00 10 00 -> wen at wadr 0x040 with wdata 0x00000013, then wen at wadr 0x041 with wdata 0x00100093; busy low afterwards.
REQ-046 Read 0x52, 00 00 01 00, 00 02 after REQ-045 -> tx bytes 13 00 00 00 93 00 10 00; i_read_sel high throughout; tx_ready held low 5 cycles mid-stream -> no byte lost or duplicated.
REQ-047 Go 0x47, 00 00 02 00 -> exactly one cpu_start pulse with start_adr = 0x00000080.
REQ-048 Write at byte address 0x00003FFC, count 2, IWIDTH=12 -> writes to wadr 0xFFF then 0x000.
REQ-049 Byte 0x41 in IDLE, then count 0000 on a write -> no wen and back to IDLE; rst_n pulsed after 2 data bytes -> no wen and all outputs 0.
